// File: rtl/sr_latch_bank_pkg.sv
// -----------------------------------------------------------------------------
// sr_latch_bank_pkg
// Shared definitions for the SR flag bank.
//   MODE_SET_DOM / MODE_RST_DOM / MODE_TOGGLE : conflict policy codes used when
//                                               s and r are both high.
//   resolve_q()                               : next flag value from the current
//                                               flag, the s/r requests and the
//                                               conflict policy.
// -----------------------------------------------------------------------------
package sr_latch_bank_pkg;

   localparam int MODE_SET_DOM = 0;
   localparam int MODE_RST_DOM = 1;
   localparam int MODE_TOGGLE  = 2;

   // Pure s/r resolution; enable, clears and the hold timer are applied by the caller.
   function automatic logic resolve_q(input logic q, input logic s, input logic r,
                                      input int mode);
      logic res;
      res = q;
      case ({s, r})
         2'b10:   res = 1'b1;
         2'b01:   res = 1'b0;
         2'b11: begin
            if (mode == MODE_SET_DOM)
               res = 1'b1;
            else if (mode == MODE_RST_DOM)
               res = 1'b0;
            else
               res = ~q;
         end
         default: res = q;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// -----------------------------------------------------------------------------
// sr_latch_bank_if
// Bundles the request and status signals of the flag bank.
//   enable  : global update enable for s/r/timer activity
//   clr_all : synchronous clear of every channel
//   s, r    : per-channel set / reset requests
//   q       : registered flag state
//   qN      : combinational ~q
//   rise    : one-cycle pulse in the first cycle q[i] reads 1
//   fall    : one-cycle pulse in the first cycle q[i] reads 0
//   any_q   : combinational OR of q
// Modports: master drives requests, slave (the bank) drives status.
// -----------------------------------------------------------------------------
interface sr_latch_bank_if #(
   parameter int CHANNELS = 8
);
   logic                enable;
   logic                clr_all;
   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] r;
   logic [CHANNELS-1:0] q;
   logic [CHANNELS-1:0] qN;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic                any_q;

   modport master (
      output enable, clr_all, s, r,
      input  q, qN, rise, fall, any_q
   );

   modport slave (
      input  enable, clr_all, s, r,
      output q, qN, rise, fall, any_q
   );
endinterface

// File: rtl/sr_latch_bank_cell.sv
// -----------------------------------------------------------------------------
// sr_latch_bank_cell
// One channel of the flag bank: registered flag, registered rise/fall pulses
// and, when SR_LATCH_BANK_AUTOCLEAR_EN is defined, a hold timer that clears the
// flag HOLD_CYCLES enabled cycles after the last set.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   enable     : update enable (hold when low)
//   clr_all    : synchronous clear, independent of enable
//   s, r       : set / reset request
//   q          : flag
//   rise, fall : one-cycle edge pulses aligned with the new level of q
// Optional feature macro: SR_LATCH_BANK_AUTOCLEAR_EN
// -----------------------------------------------------------------------------
module sr_latch_bank_cell
   import sr_latch_bank_pkg::*;
#(
   parameter int MODE        = 0,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clr_all,
   input  logic s,
   input  logic r,
   output logic q,
   output logic rise,
   output logic fall
);

   generate
      if (HOLD_CYCLES < 1 || CNT_W < 1) begin : g_bad_hold
         $error("sr_latch_bank_cell: HOLD_CYCLES and CNT_W must be >= 1");
      end
   endgenerate

   logic q_reg;
   logic rise_reg;
   logic fall_reg;
   logic q_sr;
   logic q_next;

   always_comb begin
      q_sr = resolve_q(q_reg, s, r, MODE);
   end

`ifdef SR_LATCH_BANK_AUTOCLEAR_EN
   logic [CNT_W-1:0] timer_reg;
   logic [CNT_W-1:0] timer_next;

   // Any edge that leaves the flag high with s present (fresh set, re-set or
   // toggle to 1) reloads the timer; an expiring timer overrides a plain hold.
   always_comb begin
      q_next     = q_sr;
      timer_next = timer_reg;
      if (q_sr && s) begin
         timer_next = CNT_W'(HOLD_CYCLES);
      end else if (!q_sr) begin
         timer_next = '0;
      end else if (timer_reg == CNT_W'(1)) begin
         q_next     = 1'b0;
         timer_next = '0;
      end else if (timer_reg != '0) begin
         timer_next = timer_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clr_all) begin
         timer_reg <= '0;
      end else if (enable) begin
         timer_reg <= timer_next;
      end
   end
`else
   always_comb begin
      q_next = q_sr;
   end
`endif

   // Pulses are derived from q_next vs q so they line up with the new level.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg    <= 1'b0;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else if (clr_all) begin
         q_reg    <= 1'b0;
         rise_reg <= 1'b0;
         fall_reg <= q_reg;
      end else if (!enable) begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         rise_reg <= q_next & ~q_reg;
         fall_reg <= ~q_next & q_reg;
      end
   end

   assign q    = q_reg;
   assign rise = rise_reg;
   assign fall = fall_reg;

endmodule

// File: rtl/sr_latch_bank.sv
// -----------------------------------------------------------------------------
// sr_latch_bank
// Bank of CHANNELS independent clocked set/reset flags with a selectable
// conflict policy (MODE), registered edge pulses and an optional auto-clear
// hold timer.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset, clears all state without pulses
//   bus   : sr_latch_bank_if slave modport (enable, clr_all, s, r in;
//           q, qN, rise, fall, any_q out)
// Optional feature macro: SR_LATCH_BANK_AUTOCLEAR_EN (per-channel hold timer)
// -----------------------------------------------------------------------------
module sr_latch_bank
   import sr_latch_bank_pkg::*;
#(
   parameter int CHANNELS    = 8,
   parameter int MODE        = 0,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input logic           clk,
   input logic           reset,
   sr_latch_bank_if.slave bus
);

   generate
      if (MODE != MODE_SET_DOM && MODE != MODE_RST_DOM && MODE != MODE_TOGGLE) begin : g_bad_mode
         $error("sr_latch_bank: MODE must be 0, 1 or 2");
      end
      if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
         $error("sr_latch_bank: CHANNELS must be in 1..64");
      end
   endgenerate

   logic [CHANNELS-1:0] q_vec;
   logic [CHANNELS-1:0] rise_vec;
   logic [CHANNELS-1:0] fall_vec;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cell
         sr_latch_bank_cell #(
            .MODE        (MODE),
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
         ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .enable  (bus.enable),
            .clr_all (bus.clr_all),
            .s       (bus.s[gi]),
            .r       (bus.r[gi]),
            .q       (q_vec[gi]),
            .rise    (rise_vec[gi]),
            .fall    (fall_vec[gi])
         );
      end
   endgenerate

   assign bus.q     = q_vec;
   assign bus.qN    = ~q_vec;
   assign bus.rise  = rise_vec;
   assign bus.fall  = fall_vec;
   assign bus.any_q = |q_vec;

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Clocked, parametrised successor to the single-bit SR latch: a bank of CHANNELS independent set/reset flags in one clock domain. Each channel has a selectable conflict policy, one-cycle edge pulses and an optional auto-clear hold timer. The bank serves as the status/flag store for control logic that previously instantiated individual level-sensitive latches.

## Interface
- CHANNELS, 8, number of independent flag channels (1..64)
- MODE, 0, conflict policy when s and r are both high: 0 = set-dominant, 1 = reset-dominant, 2 = toggle
- HOLD_CYCLES, 16, auto-clear hold length in enabled cycles (>=1; used only with the auto-clear macro)
- CNT_W, $clog2(HOLD_CYCLES+1), timer width (derived; do not override)
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- enable  in  1  global update enable for s/r/timer activity
- clr_all  in  1  synchronous clear of every channel; ignores enable
- s  in  CHANNELS  per-channel set request
- r  in  CHANNELS  per-channel reset request
- q  out  CHANNELS  registered flag state
- qN  out  CHANNELS  combinational ~q
- rise  out  CHANNELS  registered one-cycle pulse, high during the first cycle q[i] reads 1
- fall  out  CHANNELS  registered one-cycle pulse, high during the first cycle q[i] reads 0
- any_q  out  1  combinational OR of q

## Operation
- Priority per edge, highest first: reset, clr_all, enable=0 (hold), s/r evaluation.
- reset: q=0, rise=0, fall=0, timers=0. No fall pulse is produced by reset, even mid-operation.
- clr_all (reset low): all q to 0; fall[i]=1 for every channel where q[i] was 1; timers to 0; s/r ignored.
- enable=0: q and timers hold; rise/fall deassert.
- enable=1, per channel:
  - s only: q=1. r only: q=0. Neither: hold (subject to the timer).
  - s and r: MODE 0 gives q=1; MODE 1 gives q=0; MODE 2 gives q=~q.
- rise[i]/fall[i] are computed from q_next versus q and registered with q, so each pulse coincides exactly with the first cycle of the new level.
- MODE values other than 0..2 are illegal and are flagged by an elaboration-time check.

## Timing
- Latency: s/r sampled at edge N are visible on q after edge N; one cycle from request to output.
- qN and any_q follow q combinationally; they add no latency.
- Back-to-back set then reset on consecutive cycles yields q high for exactly one cycle, with a rise pulse in that cycle and a fall pulse in the next.
- Repeated s while q=1 produces no further rise pulses.

## Configuration
- SR_LATCH_BANK_AUTOCLEAR_EN defined:
  - A per-channel CNT_W timer loads HOLD_CYCLES on any enabled edge where q_next[i]=1 and s[i]=1, including re-set while already high and a toggle to 1.
  - Each later enabled cycle without s[i] decrements the timer.
  - When the timer is 1 and decrements, q[i] clears on that edge and fall[i] pulses.
  - An explicit clear (r per MODE, clr_all or reset) zeroes the timer.
  - Net effect: q stays high for exactly HOLD_CYCLES enabled cycles after the last set.
- Macro undefined: no timers are generated and flags persist until explicitly cleared.

## Structure
- Shared package sr_latch_bank_pkg holds localparams MODE_SET_DOM=0, MODE_RST_DOM=1 and MODE_TOGGLE=2, plus a helper function that resolves q_next from (q, s, r, mode).
- One sub-module, sr_latch_bank_cell, implements a single channel: flag, edge pulses and the optional timer. The top level instantiates it CHANNELS times with a generate loop and forms any_q.

## Test plan
- Reset, then s=8'h05 with enable=1 for one cycle: next cycle q=8'h05, rise=8'h05, any_q=1; the cycle after, rise=0 and q holds.
- MODE 0/1/2 variants, q[0]=0, s[0]=r[0]=1 for three cycles: MODE 0 gives q 1,1,1; MODE 1 gives 0,0,0; MODE 2 gives 1,0,1 with alternating rise/fall.
- enable=0 with s=8'hFF: q, rise and fall unchanged. clr_all=1 with q=8'h81 and enable=0: q=0 and fall=8'h81 on the next cycle.
- Assert reset while q=8'hFF: q=0 and fall stays 0. The first set after reset produces a normal rise.
- Auto-clear with HOLD_CYCLES=4, a single s[2] pulse: q[2] is high for exactly 4 cycles, then fall[2] pulses. Re-set at cycle 3 extends q to 4 cycles past the re-set. Drop enable for 2 cycles mid-hold: the high time extends by exactly 2 cycles.
- Auto-clear with r[2] asserted mid-hold: q[2] clears on the next edge, fall pulses once, and no second fall occurs when the old timer would have expired.
